// File: rtl/rob_commit_unit.sv
// rob_commit_unit: in-order retirement engine.
// Tracks in-flight instructions by RRF tag, collects finish reports from the
// five execution pipes and retires the oldest finished entry, one per cycle.
// The completion outputs are registered so the consumer's combinational RRF
// read (addressed by completed_dst_rrftag_o) lines up with completed_we_o.
module rob_commit_unit #(
  parameter int RRF_NUM = 64,
  parameter int RRF_SEL = 6,
  parameter int REG_SEL = 5
) (
  input  logic               clk_i,
  input  logic               reset_i,
  // dispatch
  input  logic               dp_valid_i,
  input  logic [RRF_SEL-1:0] dp_rrftag_i,
  input  logic               dp_dst_en_i,
  input  logic [REG_SEL-1:0] dp_dstnum_i,
  // finish reports
  input  logic               fin_we_alu1_i,
  input  logic [RRF_SEL-1:0] fin_rrftag_alu1_i,
  input  logic               fin_we_alu2_i,
  input  logic [RRF_SEL-1:0] fin_rrftag_alu2_i,
  input  logic               fin_we_ldst_i,
  input  logic [RRF_SEL-1:0] fin_rrftag_ldst_i,
  input  logic               fin_we_mul_i,
  input  logic [RRF_SEL-1:0] fin_rrftag_mul_i,
  input  logic               fin_we_branch_i,
  input  logic [RRF_SEL-1:0] fin_rrftag_branch_i,
  // flush
  input  logic               kill_i,
  // completion interface
  output logic [1:0]         com_inst_num_o,
  output logic               completed_we_o,
  output logic [REG_SEL-1:0] completed_dstnum_o,
  output logic [RRF_SEL-1:0] completed_dst_rrftag_o,
  // status
  output logic [RRF_SEL-1:0] comptr_o,
  output logic [RRF_SEL:0]   occupancy_o,
  output logic               empty_o,
  output logic               proto_err_o
);

  // Per-entry status bits live in flat vectors so they can be cleared in one
  // shot by reset or kill; the payload fields never need clearing.
  logic [RRF_NUM-1:0] valid_q, valid_d;
  logic [RRF_NUM-1:0] finished_q, finished_d;
  logic [RRF_NUM-1:0] fin_hit;
  logic               dst_en_q [RRF_NUM];
  logic [REG_SEL-1:0] dstnum_q [RRF_NUM];

  logic [RRF_SEL-1:0] comptr_q, comptr_d;
  logic [RRF_SEL:0]   occupancy_q, occupancy_d;
  logic               com_inst_q;
  logic               completed_we_q;
  logic [REG_SEL-1:0] completed_dstnum_q;
  logic [RRF_SEL-1:0] completed_dst_rrftag_q;
  logic               proto_err_q;

  logic dp_accept;
  logic dp_conflict;
  logic commit_ok;
  logic commit_fire;

  // One decoder per entry: any finish port naming this tag marks a hit.
  // Multiple ports on the same tag simply OR together.
  for (genvar gi = 0; gi < RRF_NUM; gi++) begin : g_fin_dec
    assign fin_hit[gi] =
        (fin_we_alu1_i   && (fin_rrftag_alu1_i   == RRF_SEL'(gi))) ||
        (fin_we_alu2_i   && (fin_rrftag_alu2_i   == RRF_SEL'(gi))) ||
        (fin_we_ldst_i   && (fin_rrftag_ldst_i   == RRF_SEL'(gi))) ||
        (fin_we_mul_i    && (fin_rrftag_mul_i    == RRF_SEL'(gi))) ||
        (fin_we_branch_i && (fin_rrftag_branch_i == RRF_SEL'(gi)));
  end

  // A dispatch onto a live entry is a protocol violation and is dropped.
  assign dp_accept   = dp_valid_i && !valid_q[dp_rrftag_i];
  assign dp_conflict = dp_valid_i &&  valid_q[dp_rrftag_i];

  // Oldest entry retires once it is both valid and finished; kill overrides.
  assign commit_ok   = valid_q[comptr_q] && finished_q[comptr_q];
  assign commit_fire = commit_ok && !kill_i;

  // Next-state of the status vectors: finish, then retire, then dispatch so a
  // same-cycle dispatch leaves its entry unfinished; kill wipes everything.
  always_comb begin
    valid_d    = valid_q;
    finished_d = finished_q | (fin_hit & valid_q);
    if (commit_ok) begin
      valid_d[comptr_q]    = 1'b0;
      finished_d[comptr_q] = 1'b0;
    end
    if (dp_accept) begin
      valid_d[dp_rrftag_i]    = 1'b1;
      finished_d[dp_rrftag_i] = 1'b0;
    end
    if (kill_i) begin
      valid_d    = '0;
      finished_d = '0;
    end
  end

  // Pointer and occupancy bookkeeping; comptr survives kill because the
  // allocator is flushed to the same position.
  always_comb begin
    comptr_d    = commit_fire ? comptr_q + RRF_SEL'(1) : comptr_q;
    occupancy_d = occupancy_q;
    if (kill_i) begin
      occupancy_d = '0;
    end else if (dp_accept && !commit_fire) begin
      occupancy_d = occupancy_q + (RRF_SEL+1)'(1);
    end else if (!dp_accept && commit_fire) begin
      occupancy_d = occupancy_q - (RRF_SEL+1)'(1);
    end
  end

  // Status, pointer and completion registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q                <= '0;
      finished_q             <= '0;
      comptr_q               <= '0;
      occupancy_q            <= '0;
      com_inst_q             <= 1'b0;
      completed_we_q         <= 1'b0;
      completed_dstnum_q     <= '0;
      completed_dst_rrftag_q <= '0;
      proto_err_q            <= 1'b0;
    end else begin
      valid_q        <= valid_d;
      finished_q     <= finished_d;
      comptr_q       <= comptr_d;
      occupancy_q    <= occupancy_d;
      com_inst_q     <= commit_fire;
      completed_we_q <= commit_fire && dst_en_q[comptr_q];
      if (commit_fire) begin
        completed_dstnum_q     <= dstnum_q[comptr_q];
        completed_dst_rrftag_q <= comptr_q;
      end
      if (dp_conflict && !kill_i) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  // Destination payload, captured on an accepted dispatch; only read while
  // the matching valid bit is set, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (dp_accept && !kill_i) begin
      dst_en_q[dp_rrftag_i] <= dp_dst_en_i;
      dstnum_q[dp_rrftag_i] <= dp_dstnum_i;
    end
  end

  assign com_inst_num_o         = {1'b0, com_inst_q};
  assign completed_we_o         = completed_we_q;
  assign completed_dstnum_o     = completed_dstnum_q;
  assign completed_dst_rrftag_o = completed_dst_rrftag_q;
  assign comptr_o               = comptr_q;
  assign occupancy_o            = occupancy_q;
  assign empty_o                = (occupancy_q == '0);
  assign proto_err_o            = proto_err_q;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed testbench for rob_commit_unit.
module tb_rob_commit_unit;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       dp_valid_i;
  logic [5:0] dp_rrftag_i;
  logic       dp_dst_en_i;
  logic [4:0] dp_dstnum_i;
  logic       fin_we_alu1_i, fin_we_alu2_i, fin_we_ldst_i, fin_we_mul_i, fin_we_branch_i;
  logic [5:0] fin_rrftag_alu1_i, fin_rrftag_alu2_i, fin_rrftag_ldst_i, fin_rrftag_mul_i, fin_rrftag_branch_i;
  logic       kill_i;
  logic [1:0] com_inst_num_o;
  logic       completed_we_o;
  logic [4:0] completed_dstnum_o;
  logic [5:0] completed_dst_rrftag_o;
  logic [5:0] comptr_o;
  logic [6:0] occupancy_o;
  logic       empty_o;
  logic       proto_err_o;

  int n_assert = 0;
  int n_fail   = 0;

  rob_commit_unit dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .dp_valid_i(dp_valid_i), .dp_rrftag_i(dp_rrftag_i),
    .dp_dst_en_i(dp_dst_en_i), .dp_dstnum_i(dp_dstnum_i),
    .fin_we_alu1_i(fin_we_alu1_i), .fin_rrftag_alu1_i(fin_rrftag_alu1_i),
    .fin_we_alu2_i(fin_we_alu2_i), .fin_rrftag_alu2_i(fin_rrftag_alu2_i),
    .fin_we_ldst_i(fin_we_ldst_i), .fin_rrftag_ldst_i(fin_rrftag_ldst_i),
    .fin_we_mul_i(fin_we_mul_i), .fin_rrftag_mul_i(fin_rrftag_mul_i),
    .fin_we_branch_i(fin_we_branch_i), .fin_rrftag_branch_i(fin_rrftag_branch_i),
    .kill_i(kill_i),
    .com_inst_num_o(com_inst_num_o), .completed_we_o(completed_we_o),
    .completed_dstnum_o(completed_dstnum_o), .completed_dst_rrftag_o(completed_dst_rrftag_o),
    .comptr_o(comptr_o), .occupancy_o(occupancy_o), .empty_o(empty_o),
    .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one cycle; inputs set before the call are sampled at this edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic idle();
    dp_valid_i = 0; dp_rrftag_i = 0; dp_dst_en_i = 0; dp_dstnum_i = 0;
    fin_we_alu1_i = 0; fin_we_alu2_i = 0; fin_we_ldst_i = 0; fin_we_mul_i = 0; fin_we_branch_i = 0;
    fin_rrftag_alu1_i = 0; fin_rrftag_alu2_i = 0; fin_rrftag_ldst_i = 0;
    fin_rrftag_mul_i = 0; fin_rrftag_branch_i = 0;
    kill_i = 0;
  endtask

  task automatic dispatch(input int tag, input logic en, input int num);
    dp_valid_i = 1; dp_rrftag_i = 6'(tag); dp_dst_en_i = en; dp_dstnum_i = 5'(num);
    tick();
    idle();
  endtask

  task automatic expect_retire(input string name, input int tag, input logic we, input int num);
    chk({name, "_com"}, 32'(com_inst_num_o), 32'd1);
    chk({name, "_we"}, 32'(completed_we_o), 32'(we));
    chk({name, "_tag"}, 32'(completed_dst_rrftag_o), 32'(tag));
    chk({name, "_num"}, 32'(completed_dstnum_o), 32'(num));
  endtask

  initial begin
    idle();
    reset_i = 1;
    tick(); tick();
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_occ", 32'(occupancy_o), 0);
    chk("rst_comptr", 32'(comptr_o), 0);
    chk("rst_com", 32'(com_inst_num_o), 0);
    chk("rst_proto", 32'(proto_err_o), 0);
    reset_i = 0;
    tick();

    // Single instruction: dispatch tag 0, finish two cycles later.
    dispatch(0, 1, 7);
    chk("single_occ1", 32'(occupancy_o), 1);
    chk("single_empty0", 32'(empty_o), 0);
    tick();
    fin_we_alu1_i = 1; fin_rrftag_alu1_i = 0;
    tick(); idle();
    chk("single_nocom_t4", 32'(com_inst_num_o), 0);
    chk("single_occ_t4", 32'(occupancy_o), 1);
    tick();
    expect_retire("single", 0, 1, 7);
    chk("single_occ0", 32'(occupancy_o), 0);
    chk("single_comptr", 32'(comptr_o), 1);
    tick();
    chk("single_pulse", 32'(com_inst_num_o), 0);
    chk("single_we_off", 32'(completed_we_o), 0);
    chk("single_num_hold", 32'(completed_dstnum_o), 7);

    // Out-of-order finish: tags 1,2,3 finish youngest first.
    dispatch(1, 1, 10);
    dispatch(2, 1, 11);
    dispatch(3, 1, 12);
    fin_we_alu2_i = 1; fin_rrftag_alu2_i = 3;
    tick(); idle();
    fin_we_ldst_i = 1; fin_rrftag_ldst_i = 2;
    tick(); idle();
    chk("ooo_wait1", 32'(com_inst_num_o), 0);
    tick();
    chk("ooo_wait2", 32'(com_inst_num_o), 0);
    fin_we_mul_i = 1; fin_rrftag_mul_i = 1;
    tick(); idle();
    chk("ooo_wait3", 32'(com_inst_num_o), 0);
    tick(); expect_retire("ooo_t1", 1, 1, 10);
    tick(); expect_retire("ooo_t2", 2, 1, 11);
    tick(); expect_retire("ooo_t3", 3, 1, 12);
    tick();
    chk("ooo_done", 32'(com_inst_num_o), 0);
    chk("ooo_comptr", 32'(comptr_o), 4);
    chk("ooo_occ", 32'(occupancy_o), 0);

    // Entry without destination still retires.
    dispatch(4, 0, 3);
    fin_we_branch_i = 1; fin_rrftag_branch_i = 4;
    tick(); idle();
    tick();
    expect_retire("nodst", 4, 0, 3);

    // Asynchronous reset mid-stream with five live entries.
    for (int k = 5; k < 10; k++) dispatch(k, 1, k);
    chk("pre_rst_occ", 32'(occupancy_o), 5);
    #2;
    reset_i = 1;
    #1;
    chk("arst_empty", 32'(empty_o), 1);
    chk("arst_occ", 32'(occupancy_o), 0);
    chk("arst_comptr", 32'(comptr_o), 0);
    chk("arst_tag", 32'(completed_dst_rrftag_o), 0);
    chk("arst_num", 32'(completed_dstnum_o), 0);
    chk("arst_we", 32'(completed_we_o), 0);
    chk("arst_com", 32'(com_inst_num_o), 0);
    chk("arst_proto", 32'(proto_err_o), 0);
    tick();
    reset_i = 0;
    tick();

    // Fill all 64 entries, finish in reverse across all ports, drain.
    for (int k = 0; k < 64; k++) dispatch(k, logic'(k % 2), k % 32);
    chk("full_occ", 32'(occupancy_o), 64);
    for (int g = 63; g >= 0; g -= 5) begin
      fin_we_alu1_i = 1; fin_rrftag_alu1_i = 6'(g);
      if (g >= 1) begin fin_we_alu2_i = 1; fin_rrftag_alu2_i = 6'(g - 1); end
      if (g >= 2) begin fin_we_ldst_i = 1; fin_rrftag_ldst_i = 6'(g - 2); end
      if (g >= 3) begin fin_we_mul_i = 1; fin_rrftag_mul_i = 6'(g - 3); end
      if (g >= 4) begin fin_we_branch_i = 1; fin_rrftag_branch_i = 6'(g - 4); end
      tick(); idle();
    end
    chk("wrap_nocom_yet", 32'(com_inst_num_o), 0);
    for (int k = 0; k < 64; k++) begin
      tick();
      expect_retire($sformatf("wrap_%0d", k), k, logic'(k % 2), k % 32);
    end
    chk("wrap_comptr", 32'(comptr_o), 0);
    tick();
    chk("wrap_done", 32'(com_inst_num_o), 0);
    chk("wrap_empty", 32'(empty_o), 1);
    chk("wrap_proto", 32'(proto_err_o), 0);

    // Redispatch tag 0 after the wrap.
    dispatch(0, 1, 21);
    fin_we_alu2_i = 1; fin_rrftag_alu2_i = 0;
    tick(); idle();
    tick();
    expect_retire("redisp", 0, 1, 21);
    chk("redisp_comptr", 32'(comptr_o), 1);
    chk("redisp_proto", 32'(proto_err_o), 0);

    // Finish to an invalid entry is ignored.
    fin_we_ldst_i = 1; fin_rrftag_ldst_i = 1;
    tick(); idle();
    dispatch(1, 1, 2);
    tick(); tick();
    chk("inv_fin_nocom", 32'(com_inst_num_o), 0);
    chk("inv_fin_occ", 32'(occupancy_o), 1);
    chk("inv_fin_comptr", 32'(comptr_o), 1);

    // Dispatch onto a live entry flags a sticky protocol error.
    dispatch(1, 0, 9);
    chk("proto_set", 32'(proto_err_o), 1);
    chk("proto_occ", 32'(occupancy_o), 1);
    tick();
    chk("proto_sticky", 32'(proto_err_o), 1);

    // Kill with ten live entries, three finished, plus a same-cycle finish.
    for (int k = 2; k < 11; k++) dispatch(k, 1, k);
    chk("kill_pre_occ", 32'(occupancy_o), 10);
    fin_we_alu1_i = 1; fin_rrftag_alu1_i = 4;
    fin_we_alu2_i = 1; fin_rrftag_alu2_i = 5;
    fin_we_ldst_i = 1; fin_rrftag_ldst_i = 6;
    tick(); idle();
    kill_i = 1;
    fin_we_mul_i = 1; fin_rrftag_mul_i = 1;
    tick(); idle();
    chk("kill_occ", 32'(occupancy_o), 0);
    chk("kill_empty", 32'(empty_o), 1);
    chk("kill_comptr", 32'(comptr_o), 1);
    chk("kill_com", 32'(com_inst_num_o), 0);
    chk("kill_proto", 32'(proto_err_o), 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("kill_quiet_com_%0d", k), 32'(com_inst_num_o), 0);
      chk($sformatf("kill_quiet_we_%0d", k), 32'(completed_we_o), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
